// File: rtl/sum_accum_ctrl.sv
// Sums LEN operands through an external combinational full_adder, tracks a sticky
// carry-out overflow flag and offers the result on a valid/ready port.
module sum_accum_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic [WIDTH-1:0] add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               beat;

  // Only the carry out of the top bit matters; the rest of add_c is don't-care.
  logic unused_add_c;
  assign unused_add_c = ^add_c[WIDTH-1:1];

  assign beat = in_valid && (state_q == ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_c[0];
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status decodes straight from the state register; sum/overflow held in flops.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = acc_q;
  assign overflow  = ovf_q;
  assign add_a     = acc_q;
  assign add_b     = (state_q == ACC) ? in_data : '0;

endmodule

// File: tb/tb_sum_accum_ctrl.sv
// Bench for sum_accum_ctrl: behavioural full_adder, queue scoreboard fed by a
// running-sum model, one task per scenario.
module tb_sum_accum_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] add_a, add_b, add_s, add_c;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             overflow, busy;

  logic             carry;
  logic [WIDTH-1:0] junk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  int               tests = 0;
  int               fails = 0;
  int               m_rem;
  logic [WIDTH-1:0] m_sum;
  logic             m_ovf;

  always #5 clk = ~clk;

  // full_adder stand-in; upper carry bits carry junk that the DUT must ignore
  assign {carry, add_s} = {1'b0, add_a} + {1'b0, add_b};
  assign add_c = {junk[WIDTH-1:1], carry};

  sum_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .overflow(overflow), .busy(busy)
  );

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(n);
    m_rem = n;
    m_sum = '0;
    m_ovf = 1'b0;
    if (n == 0) begin
      e.sum = '0; e.ovf = 1'b0; sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    in_valid = 1'b1;
    in_data  = d;
    junk     = $urandom() & 32'hFFFF_FFFE;
    @(negedge clk);
    in_valid = 1'b0;
    if (m_rem > 0) begin
      t     = {1'b0, m_sum} + {1'b0, d};
      m_sum = t[WIDTH-1:0];
      m_ovf = m_ovf | t[WIDTH];
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        e.sum = m_sum; e.ovf = m_ovf; sb.push_back(e);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for out_valid, capture result, complete the handshake.
  task automatic collect(output logic got, output logic [WIDTH-1:0] s, output logic o);
    got = 1'b0; s = '0; o = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      s = sum_out;
      o = overflow;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, overflow} !== 4'b0000 || sum_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b ovf=%b sum=%h, want all 0",
               in_ready, out_valid, busy, overflow, sum_out);
    end
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_basic;
    logic got, o; logic [WIDTH-1:0] s;
    do_start(4);
    beat(1); beat(2); beat(3); beat(4);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL basic_latency: out_valid=%b want 1", out_valid);
    end
    collect(got, s, o);
    e = sb.pop_front();
    tests++;
    if (got !== 1'b1 || s !== e.sum || o !== e.ovf || s !== 32'd10) begin
      fails++; $display("FAIL basic_sum: got=%b sum=%0d ovf=%b want sum=%0d ovf=%b",
                        got, s, o, e.sum, e.ovf);
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum_out !== 32'd10) begin
      fails++; $display("FAIL basic_retain: busy=%b vld=%b sum=%0d want 0 0 10",
                        busy, out_valid, sum_out);
    end
  endtask

  task automatic test_wrap;
    logic got, o; logic [WIDTH-1:0] s;
    do_start(2);
    beat(32'hFFFF_FFFF); beat(32'h2);
    collect(got, s, o);
    e = sb.pop_front();
    tests++;
    if (got !== 1'b1 || s !== e.sum || o !== e.ovf || s !== 32'h1 || o !== 1'b1) begin
      fails++; $display("FAIL wrap: got=%b sum=%h ovf=%b want sum=%h ovf=%b",
                        got, s, o, e.sum, e.ovf);
    end
  endtask

  task automatic test_gaps;
    logic got, o; logic [WIDTH-1:0] s;
    do_start(3);
    beat(5); idle_cycles(2); beat(6); idle_cycles(1); beat(7);
    // operand presented while in DONE must not be absorbed
    in_valid = 1'b1; in_data = 32'd100;
    idle_cycles(3);
    in_valid = 1'b0;
    collect(got, s, o);
    e = sb.pop_front();
    tests++;
    if (got !== 1'b1 || s !== e.sum || o !== e.ovf || s !== 32'd18) begin
      fails++; $display("FAIL gaps: got=%b sum=%0d ovf=%b want sum=%0d ovf=%b",
                        got, s, o, e.sum, e.ovf);
    end
  endtask

  task automatic test_len_zero;
    logic got, o; logic [WIDTH-1:0] s;
    do_start(0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || sum_out !== '0 || overflow !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL len0_hold[%0d]: vld=%b sum=%h ovf=%b rdy=%b want 1 0 0 0",
                          i, out_valid, sum_out, overflow, in_ready);
      end
      @(negedge clk);
    end
    collect(got, s, o);
    e = sb.pop_front();
    tests++;
    if (got !== 1'b1 || s !== e.sum || o !== e.ovf) begin
      fails++; $display("FAIL len0_result: got=%b sum=%h ovf=%b want %h %b", got, s, o, e.sum, e.ovf);
    end
  endtask

  task automatic test_start_ignored;
    logic got, o; logic [WIDTH-1:0] s;
    do_start(2);
    tests++;
    if (sum_out !== '0 || overflow !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL start_clears: sum=%h ovf=%b busy=%b want 0 0 1", sum_out, overflow, busy);
    end
    beat(10);
    start = 1'b1; len = CNT_W'(9);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++; $display("FAIL start_ignored_state: busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    beat(20);
    collect(got, s, o);
    e = sb.pop_front();
    tests++;
    if (got !== 1'b1 || s !== e.sum || o !== e.ovf || s !== 32'd30) begin
      fails++; $display("FAIL start_ignored_sum: got=%b sum=%0d want %0d", got, s, e.sum);
    end
  endtask

  task automatic test_reset_mid;
    logic got, o; logic [WIDTH-1:0] s;
    do_start(4);
    beat(1); beat(2);
    rst_n = 1'b0;
    m_rem = 0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || sum_out !== '0) begin
      fails++; $display("FAIL reset_mid: rdy=%b busy=%b vld=%b sum=%h want 0 0 0 0",
                        in_ready, busy, out_valid, sum_out);
    end
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(3);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_quiet: vld=%b busy=%b want 0 0", out_valid, busy);
    end
    do_start(1);
    beat(7);
    collect(got, s, o);
    e = sb.pop_front();
    tests++;
    if (got !== 1'b1 || s !== e.sum || o !== e.ovf || s !== 32'd7) begin
      fails++; $display("FAIL reset_mid_restart: got=%b sum=%0d want %0d", got, s, e.sum);
    end
  endtask

  task automatic test_back_to_back;
    logic got, o; logic [WIDTH-1:0] s;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 8);
      do_start(n);
      for (int k = 0; k < n; k++) beat((r >= 2) ? $urandom() : WIDTH'($urandom_range(0, 1000)));
      collect(got, s, o);
      e = sb.pop_front();
      tests++;
      if (got !== 1'b1 || s !== e.sum || o !== e.ovf) begin
        fails++; $display("FAIL b2b[%0d]: got=%b sum=%h ovf=%b want %h %b", r, got, s, o, e.sum, e.ovf);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
  endtask

  initial begin
    start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; junk = '0; m_rem = 0; m_sum = '0; m_ovf = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_len_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
